// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg - shared state encoding, parity codes and divider helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, floored; never below one clock.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_fifo - small register FIFO; push on full is taken only     |
// | when a pop happens in the same cycle.  Rev 1.0                     |
// +--------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_param - configurable oversampled UART receiver with FIFO.  |
// | Optional UART_RX_MAJORITY_EN: 2-of-3 majority bit decision.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = $clog2(DIV) + 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int EW  = DATA_BITS + 3;
`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE_AT = OVERSAMPLE / 2;
`else
    localparam int DECIDE_AT = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [SW-1:0] DECIDE_CNT = SW'(DECIDE_AT);
    localparam logic [SW-1:0] LAST_CNT   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

    rx_state_t            state, state_next;
    logic                 rx_meta, rx_sync, rx_prev, fall;
    logic [DW-1:0]        div_cnt;
    logic [SW-1:0]        samp_cnt;
    logic                 tick, decide, bit_end, bit_val;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx, last_stop;
    logic                 frame_err, parity_err, brk;
    logic                 frame_err_now, brk_now;
    logic [EW-1:0]        entry, head;
    logic                 push, pop, full, empty, overrun;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign decide    = tick && (samp_cnt == DECIDE_CNT);
    assign bit_end   = tick && (samp_cnt == LAST_CNT);
    assign last_stop = (stop_idx == LAST_STOP);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            early <= 2'b11;
        end else if (tick && (samp_cnt == SW'(OVERSAMPLE/2 - 2) ||
                              samp_cnt == SW'(OVERSAMPLE/2 - 1))) begin
            early <= {early[0], rx_sync};
        end
    end

    assign bit_val = (early[1] & early[0]) | (early[1] & rx_sync) | (early[0] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    // Stop-bit results merge into the entry combinationally so the push needs no extra tick.
    assign frame_err_now = frame_err | ~bit_val;
    assign brk_now       = (stop_idx == 1'b0) ? ((shift_reg == '0) & ~bit_val) : brk;
    assign entry         = {brk_now, frame_err_now, parity_err, shift_reg};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START: begin
                if (decide && bit_val) state_next = ST_IDLE;
                else if (bit_end)      state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == LAST_BIT))
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (decide && last_stop) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != ST_IDLE);
        push   = (state == ST_STOP) && decide && last_stop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt    <= '0;
            samp_cnt   <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
        end else if (state == ST_IDLE) begin
            div_cnt    <= '0;
            samp_cnt   <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                samp_cnt <= bit_end ? '0 : samp_cnt + 1'b1;
            end
            if (decide) begin
                case (state)
                    ST_DATA:   shift_reg  <= {bit_val, shift_reg[DATA_BITS-1:1]};
                    ST_PARITY: parity_err <= (((^shift_reg) ^ bit_val) != (PARITY == PAR_ODD));
                    ST_STOP: begin
                        frame_err <= frame_err_now;
                        brk       <= brk_now;
                    end
                    default: ;
                endcase
            end
            if (bit_end) begin
                if ((state == ST_DATA) && (bit_idx != LAST_BIT)) bit_idx <= bit_idx + 1'b1;
                if (state == ST_STOP) stop_idx <= 1'b1;
            end
        end
    end

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
        end
    end

    assign overrun_o = overrun;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  (entry),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    assign {break_o, frame_err_o, parity_err_o, data_o} = head;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_param - randomised scoreboard bench for uart_rx_param   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_rx_param;

    localparam int BAUD    = 115_200;
    localparam int OS      = 16;
    localparam int CLK_HZ  = BAUD * OS * 4;
    localparam int DIV     = 4;
    localparam int BITCLK  = DIV * OS;
    localparam int DB      = 8;
    localparam int PAR     = 2;
    localparam int SB      = 1;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic          brk;
        logic          ferr;
        logic          perr;
        logic [DB-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          ready;
    logic [DB-1:0] data;
    logic          perr, ferr, brk, valid, overrun, busy;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ovr = 0;
    int   ovr_seen = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY     (PAR),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .data_o       (data),
        .parity_err_o (perr),
        .frame_err_o  (ferr),
        .break_o      (brk),
        .valid_o      (valid),
        .ready_i      (ready),
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        clks(BITCLK);
    endtask

    // Reference: a frame's flags follow directly from the bits put on the line.
    task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit stop_low);
        ent_t e;
        logic pbit;
        int   ones;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        pbit = (($countones(d) % 2) == ((PAR == 1) ? 0 : 1)) ? 1'b1 : 1'b0;
        if (PAR == 2) pbit = ($countones(d) % 2 == 1);
        pbit = pbit ^ bad_par;
        if (PAR != 0) drive_bit(pbit);
        ones   = $countones(d) + ((PAR != 0) ? int'(pbit) : 0);
        e.data = d;
        e.perr = (PAR == 2) ? (ones % 2 == 1) : (PAR == 1) ? (ones % 2 == 0) : 1'b0;
        e.ferr = stop_low;
        e.brk  = (d == '0) && stop_low;
        if (model_q.size() < DEPTH) model_q.push_back(e);
        else                        exp_ovr++;
        drive_bit(~stop_low);
        for (int s = 1; s < SB; s++) drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (model_q.size() == 0 && !valid) break;
            clks(1);
        end
        check(name, model_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_head"}, {brk, ferr, perr, data}, 0);
    endtask

    // Monitor: pops compare against the scoreboard; held heads must match too.
    always @(negedge clk) begin
        if (overrun) ovr_seen++;
        if (rst_n && valid) begin
            if (model_q.size() == 0) begin
                check("unexpected_entry", {brk, ferr, perr, data}, 32'hDEAD);
            end else if (ready) begin
                ent_t e;
                e = model_q.pop_front();
                check("pop_data", data, e.data);
                check("pop_perr", perr, e.perr);
                check("pop_ferr", ferr, e.ferr);
                check("pop_brk",  brk,  e.brk);
            end else begin
                check("held_head", {brk, ferr, perr, data}, model_q[0]);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        clks(5);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clks(BITCLK);

        // Clean frame held until the consumer is ready.
        send_frame(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("a5_valid_held", valid, 1);
        check("a5_data", data, 8'hA5);
        clks(1);
        ready = 1'b1;
        wait_drain("drain_a5");

        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        wait_drain("drain_flags");

        // Short low glitch must be rejected as a false start.
        rx = 1'b0;
        clks(6);
        @(negedge clk);
        check("glitch_busy_hi", busy, 1);
        clks(3 * DIV - 6);
        rx = 1'b1;
        clks(BITCLK);
        @(negedge clk);
        check("glitch_busy_lo", busy, 0);
        check("glitch_no_push", valid, 0);
        clks(1);

        // Overflow: four held, fifth dropped with one overrun pulse.
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b0);
        clks(4);
        check("ovr_count", ovr_seen, exp_ovr);
        check("ovr_expected_one", exp_ovr, 1);
        check("ovr_queue", model_q.size(), DEPTH);
        ready = 1'b1;
        wait_drain("drain_ovr");

        // Reset in the middle of a data phase drops the partial frame.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx    = 1'b1;
        rst_n = 1'b0;
        clks(4);
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clks(BITCLK);
        send_frame(8'h81, 1'b0, 1'b0);
        wait_drain("drain_81");

        // Randomised frames with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0));
        end
        clks(8);
        rand_ready = 1'b0;
        clks(1);
        ready = 1'b1;
        wait_drain("drain_random");
        check("ovr_final", ovr_seen, exp_ovr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial-link front end. It synchronises the `rx_i` line, recovers frames with an oversampled baud tick, and checks parity and stop bits per frame. Received words and their error flags are buffered in a small FIFO and handed to the consumer with a valid/ready handshake. It replaces the fixed 8N1 receiver chain (start detect, bit capture, frame check) with one configurable block.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115_200: line rate.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: payload width, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two, ≥2.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial line, idle high, asynchronous.
- `data_o` out DATA_BITS: head-of-FIFO payload, LSB received first.
- `parity_err_o` out 1: head entry failed parity; 0 when PARITY=0.
- `frame_err_o` out 1: head entry had a low stop bit.
- `break_o` out 1: head entry is all-zero data with a low first stop bit.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer accepts head entry.
- `overrun_o` out 1: one-cycle pulse when a completed frame is dropped.
- `busy_o` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Two-flop synchroniser on `rx_i`, both flops reset to 1. Falling-edge detection compares the second flop with a third, also reset to 1.
- Tick generator: `DIV = CLK_HZ/(BAUD*OVERSAMPLE)`, rounded down. The counter is held at 0 in IDLE, so phase aligns to the start edge. `tick` asserts one cycle every DIV clocks.
- Sample counter 0..OVERSAMPLE-1 counts ticks. The bit sample is taken at count `OVERSAMPLE/2-1`. The bit ends at `OVERSAMPLE-1`.
- FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a synchronised falling edge.
  - START: at mid-sample, a high line returns to IDLE as a false start with nothing pushed. A low line goes to DATA at bit end.
  - DATA: shift sampled bits LSB-first into a DATA_BITS register. After bit DATA_BITS-1 ends, go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample the bit. `parity_err = (^data ^ bit) != (PARITY==1)`.
  - STOP: sample the first stop bit. Low sets `frame_err`. With STOP_BITS=2, the second stop bit is also checked and ORs into `frame_err`. At the mid-sample of the final stop bit, push the entry and go to IDLE without waiting for bit end.
- FIFO entry is {break, frame_err, parity_err, data}.
  - Pop when `valid_o && ready_i`.
  - Push when full without a same-cycle pop: the entry is dropped, `overrun_o` pulses, and FIFO contents are unchanged.
  - Push when full with a same-cycle pop: accepted, no overrun.
- Pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: FSM in IDLE, counters 0, FIFO empty, `valid_o` 0, `overrun_o` 0, `busy_o` 0, all data/flag outputs 0.
- Reset mid-frame clears the partial frame. After release, a new frame needs a fresh falling edge.
- Edge-to-START latency: 3 clocks (two synchroniser flops plus the edge flop).
- Push occurs on the clock after the final stop-bit mid-sample tick. `valid_o` rises on the following clock.
- Outputs are registered, read from the FIFO head. `data_o` and flags are stable while `valid_o && !ready_i`.
- Back-to-back frames work: the next start edge is detected in IDLE during the second half of the stop bit.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at counts `OVERSAMPLE/2-2`, `-1` and `+0`. This also applies to START false-start detection. The decision is taken at count `OVERSAMPLE/2`, so the push moves one tick later.
- Undefined: a single sample at `OVERSAMPLE/2-1`.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Parity encoding constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - A function computing DIV from CLK_HZ/BAUD/OVERSAMPLE.
- Sub-module `uart_rx_fifo`:
  - Parametrised width and depth.
  - Push/pop/full/empty.
  - Same-cycle push+pop on full is allowed.

## Test plan
- 8N1 at DIV=4, OVERSAMPLE=16, send 0xA5 → one entry with `data_o`=0xA5, all flags 0, `valid_o` high until `ready_i`.
- PARITY=2 (even), send 0x07 with parity bit 0 → `parity_err_o`=1. Same frame with parity bit 1 → `parity_err_o`=0.
- Drive the stop bit low on 0x00 → `frame_err_o`=1 and `break_o`=1. Send 0x01 with a low stop bit → `frame_err_o`=1, `break_o`=0.
- Low glitch of 3 ticks in IDLE → false start, no push, `busy_o` returns to 0.
- FIFO_DEPTH=4, `ready_i`=0, send 5 frames → 4 entries held, `overrun_o` pulses once on the 5th. Pop all → values 1..4 in order.
- Assert `rst_ni` mid-DATA of 0x3C, release, send 0x81 → single entry 0x81, no flags.
